// File: rtl/delayed_ack_responder_if.sv
// Request/acknowledge bundle between a requester and the delayed-ack responder.
// The master drives en/a; the slave returns the echo, ack, status and counters.
interface delayed_ack_responder_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             a;
    logic             y;
    logic             b;
    logic             drop;
    logic             busy;
    logic             full;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output en, a,
        input  y, b, drop, busy, full, req_cnt, ack_cnt, drop_cnt
    );

    modport slave (
        input  en, a,
        output y, b, drop, busy, full, req_cnt, ack_cnt, drop_cnt
    );
endinterface

// File: rtl/delayed_ack_responder.sv
// Responder for a |-> ##DELAY b: fixed-latency acknowledge pipeline with an
// outstanding-request limit, drop pulses and saturating statistics counters.
module delayed_ack_responder #(
    parameter int DELAY           = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    delayed_ack_responder_if.slave bus
);
    localparam logic [3:0]       MAX_O   = 4'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DELAY-1:0] pipe;
    logic [DELAY-1:0] pipe_nxt;
    logic [3:0]       outs;
    logic [3:0]       outs_free;
    logic [3:0]       outs_nxt;
    logic             ack_now;
    logic             req;
    logic             accept;
    logic             reject;
    logic             drop_q;
    logic             busy_q;
    logic             full_q;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] drop_cnt;

    assign ack_now = pipe[DELAY-1];
    assign req     = bus.en & bus.a;

    // A slot released by this edge's acknowledge may be taken by this edge's request.
    always_comb begin
        outs_free = outs - {3'b000, ack_now};
        accept    = req & (outs_free < MAX_O);
        reject    = req & ~accept;
        outs_nxt  = outs_free + {3'b000, accept};
        pipe_nxt    = pipe << 1;
        pipe_nxt[0] = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe     <= '0;
            outs     <= '0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            req_cnt  <= '0;
            ack_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            pipe   <= pipe_nxt;
            outs   <= outs_nxt;
            drop_q <= reject;
            busy_q <= (outs_nxt != 4'd0);
            full_q <= (outs_nxt == MAX_O);
            if (accept && req_cnt != CNT_MAX)
                req_cnt <= req_cnt + 1'b1;
            if (ack_now && ack_cnt != CNT_MAX)
                ack_cnt <= ack_cnt + 1'b1;
            if (reject && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.y        = bus.a;
    assign bus.b        = pipe[DELAY-1];
    assign bus.drop     = drop_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.req_cnt  = req_cnt;
    assign bus.ack_cnt  = ack_cnt;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_delayed_ack_responder.sv
// Bench for delayed_ack_responder: scoreboard of due acknowledges plus
// per-scenario expectations; a second instance exercises counter saturation.
module tb_delayed_ack_responder;
    localparam int DELAY = 3;
    localparam int MAXO  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delayed_ack_responder_if #(.CNT_W(16)) bus ();
    delayed_ack_responder_if #(.CNT_W(4))  sbus ();

    delayed_ack_responder #(
        .DELAY(DELAY), .MAX_OUTSTANDING(MAXO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    delayed_ack_responder #(
        .DELAY(3), .MAX_OUTSTANDING(4), .CNT_W(4)
    ) dut_s (
        .clk(clk), .rst(rst), .bus(sbus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int due_q[$];
    bit e_b, e_drop, e_busy, e_full;
    int e_req, e_ack, e_dcnt;

    // Advance one edge and update the expected state of the main instance.
    task automatic tick();
        bit ack_now;
        bit acc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            due_q.delete();
            e_drop = 0;
            e_req  = 0;
            e_ack  = 0;
            e_dcnt = 0;
        end else begin
            ack_now = (due_q.size() > 0) && (due_q[0] == cyc);
            if (ack_now) begin
                void'(due_q.pop_front());
                if (e_ack < 65535) e_ack++;
            end
            acc = bus.en && bus.a && (due_q.size() < MAXO);
            if (acc) begin
                due_q.push_back(cyc + DELAY);
                if (e_req < 65535) e_req++;
            end
            e_drop = bus.en && bus.a && !acc;
            if (e_drop && e_dcnt < 65535) e_dcnt++;
        end
        e_busy = (due_q.size() != 0);
        e_full = (due_q.size() == MAXO);
        e_b    = (due_q.size() > 0) && (due_q[0] == cyc + 1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.a = 1'b0;
        sbus.a = 1'b0;
        tick();
        rst = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.a = ~bus.a;
            #1;
            n_chk++;
            if (bus.y !== bus.a) begin
                n_fail++;
                $display("FAIL reset_y got %b exp %b", bus.y, bus.a);
            end
            tick();
            n_chk++;
            if ({bus.b, bus.drop, bus.busy, bus.full} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_flags got %b exp 0000",
                         {bus.b, bus.drop, bus.busy, bus.full});
            end
            n_chk++;
            if ({bus.req_cnt, bus.ack_cnt, bus.drop_cnt} !== 48'd0) begin
                n_fail++;
                $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0",
                         bus.req_cnt, bus.ack_cnt, bus.drop_cnt);
            end
        end
        rst = 1'b0;
        bus.a = 1'b0;
    endtask

    task automatic test_single();
        int k;
        do_reset();
        tick();
        tick();
        bus.a = 1'b1;
        tick();
        k = cyc;
        bus.a = 1'b0;
        for (int j = 0; j < 5; j++) begin
            n_chk++;
            if (bus.b !== (cyc == k + 2) || bus.b !== e_b) begin
                n_fail++;
                $display("FAIL single_b edge %0d got %b exp %b", cyc - k,
                         bus.b, (cyc == k + 2));
            end
            n_chk++;
            if (bus.busy !== (cyc <= k + 2)) begin
                n_fail++;
                $display("FAIL single_busy edge %0d got %b exp %b", cyc - k,
                         bus.busy, (cyc <= k + 2));
            end
            tick();
        end
        n_chk++;
        if (bus.req_cnt !== 16'd1 || bus.ack_cnt !== 16'd1 || bus.drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL single_cnt got %0d/%0d/%0d exp 1/1/0",
                     bus.req_cnt, bus.ack_cnt, bus.drop_cnt);
        end
    endtask

    task automatic test_saturation();
        bit xb, xd, xf;
        do_reset();
        bus.a = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            if (j == 5) bus.a = 1'b0;
            tick();
            xb = (j == 3) || (j == 4) || (j == 6);
            xd = (j == 3);
            xf = (j >= 2) && (j <= 4);
            n_chk++;
            if (bus.b !== xb || bus.b !== e_b) begin
                n_fail++;
                $display("FAIL sat_b E%0d got %b exp %b", j, bus.b, xb);
            end
            n_chk++;
            if (bus.drop !== xd || bus.drop !== e_drop) begin
                n_fail++;
                $display("FAIL sat_drop E%0d got %b exp %b", j, bus.drop, xd);
            end
            n_chk++;
            if (bus.full !== xf || bus.full !== e_full) begin
                n_fail++;
                $display("FAIL sat_full E%0d got %b exp %b", j, bus.full, xf);
            end
        end
        n_chk++;
        if (bus.req_cnt !== 16'd3 || bus.ack_cnt !== 16'd3 ||
            bus.drop_cnt !== 16'd1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_final got %0d/%0d/%0d busy %b exp 3/3/1 busy 0",
                     bus.req_cnt, bus.ack_cnt, bus.drop_cnt, bus.busy);
        end
    endtask

    task automatic test_enable_off();
        do_reset();
        bus.en = 1'b0;
        bus.a = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_chk++;
            if (bus.b !== 1'b0 || bus.drop !== 1'b0 ||
                bus.req_cnt !== 16'd0 || bus.drop_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL en_off got b %b drop %b req %0d dcnt %0d exp all 0",
                         bus.b, bus.drop, bus.req_cnt, bus.drop_cnt);
            end
        end
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        for (int j = 2; j <= 5; j++) begin
            tick();
            n_chk++;
            if (bus.b !== (j == 3) || bus.b !== e_b) begin
                n_fail++;
                $display("FAIL en_drain_b E%0d got %b exp %b", j, bus.b, (j == 3));
            end
        end
        n_chk++;
        if (bus.req_cnt !== 16'd1 || bus.ack_cnt !== 16'd1 || bus.drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL en_drain_cnt got %0d/%0d/%0d exp 1/1/0",
                     bus.req_cnt, bus.ack_cnt, bus.drop_cnt);
        end
        bus.en = 1'b1;
        bus.a = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        bus.a = 1'b1;
        tick();
        bus.a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (bus.req_cnt !== 16'd0 || bus.ack_cnt !== 16'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rif_state got req %0d ack %0d busy %b exp 0/0/0",
                     bus.req_cnt, bus.ack_cnt, bus.busy);
        end
        for (int j = 2; j <= 6; j++) begin
            n_chk++;
            if (bus.b !== 1'b0 || bus.b !== e_b) begin
                n_fail++;
                $display("FAIL rif_b E%0d got %b exp 0", j, bus.b);
            end
            tick();
        end
    endtask

    task automatic test_counter_sat();
        int xr, xa;
        do_reset();
        sbus.en = 1'b1;
        sbus.a = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            if (n == 21) sbus.a = 1'b0;
            tick();
            xr = (n < 20) ? n : 20;
            xr = (xr < 15) ? xr : 15;
            xa = (n > 3) ? n - 3 : 0;
            xa = (xa < 20) ? xa : 20;
            xa = (xa < 15) ? xa : 15;
            n_chk++;
            if (sbus.b !== (n >= 3 && n <= 22)) begin
                n_fail++;
                $display("FAIL csat_b E%0d got %b exp %b", n, sbus.b,
                         (n >= 3 && n <= 22));
            end
            n_chk++;
            if (sbus.req_cnt !== 4'(xr) || sbus.ack_cnt !== 4'(xa)) begin
                n_fail++;
                $display("FAIL csat_cnt E%0d got %0d/%0d exp %0d/%0d", n,
                         sbus.req_cnt, sbus.ack_cnt, xr, xa);
            end
            n_chk++;
            if (sbus.drop_cnt !== 4'd0 || sbus.drop !== 1'b0 || sbus.y !== sbus.a) begin
                n_fail++;
                $display("FAIL csat_drop E%0d got dcnt %0d drop %b y %b exp 0 0 %b", n,
                         sbus.drop_cnt, sbus.drop, sbus.y, sbus.a);
            end
        end
        sbus.en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.a = 1'b0;
        sbus.en = 1'b0;
        sbus.a = 1'b0;
        test_reset();
        test_single();
        test_saturation();
        test_enable_off();
        test_reset_in_flight();
        test_counter_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
